pt2272_decoder: RTL and testbench
=================================

# pt2272_decoder

- Receive-side decoder for the PT2262/PT2272 remote-code link: samples the serial PWM stream produced by the encoder, classifies pulse widths in units of the oscillator period α, and rebuilds tri-state address bits and binary data bits.
- Latches data and asserts valid-transmission (VT) after two consecutive identical words whose address matches the local address setting.
- Sits behind the RF/line input, clocked from the same divided oscillator domain as the encoder.

## Interface
- ALPHA_CYCLES, 16: INPUT_CLK cycles per α (≥4).
- ADDR_BITS, 8: tri-state address bits per word.
- DATA_BITS, 4: binary data bits per word (ADDR_BITS+DATA_BITS = 12).
- INPUT_CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- DIN  in  1  raw serial code input, asynchronous to INPUT_CLK.
- ADDR_SET  in  2*ADDR_BITS  local address, 2 bits per pin [2i+1:2i]: 00=0, 11=1, 01=F; 10 never matches.
- DATA_OUT  out  DATA_BITS  latched data, D0 at bit 0.
- VT  out  1  valid transmission.
- CODE_ERR  out  1  one-cycle pulse on any framing/pulse error.

## Operation
- DIN passes through a 2-flop synchronizer; all widths are measured on the synchronized signal `din_s`.
- Width counter counts INPUT_CLK cycles of the current `din_s` level, restarting at 1 on each edge. It saturates at 64α.
- High-width class at the falling edge:
  - short: 2α ≤ w < 8α
  - long: 8α ≤ w ≤ 16α
  - anything else is an error.
  - A high still running at 16α+1 is an error immediately.
- Low-width class, same limits. Short-high followed by a low reaching 64α is SYNC; a low in (16α, 64α) is an error.
- Symbol at the rising edge ending the low:
  - short-high + long-low = S
  - long-high + short-low = L
  - any other pairing is an error.
- Bit from two symbols: SS=0, LL=1, SL=F, LS=error. Bits arrive A0 first, then address in order, then D0…D(DATA_BITS-1).
- FSM states: WAIT_SYNC, MEAS_HIGH, MEAS_LOW, EVAL.
  - WAIT_SYNC: discards everything until a SYNC, then goes to MEAS_HIGH with bit count 0.
  - MEAS_HIGH: measures the high; goes to MEAS_LOW on the falling edge.
  - MEAS_LOW: measures the low; returns to MEAS_HIGH on the rising edge; goes to EVAL on SYNC.
  - EVAL: lasts one cycle, then returns to WAIT_SYNC-equivalent alignment (the SYNC just seen counts as the leading sync of the next word).
- Word evaluation happens at SYNC.
  - The word is good only if exactly 12 bits were collected, every address bit equals the ADDR_SET pin, and no data bit is F.
  - Good word: if `first_ok` is set and the stored data equals the new data, update DATA_OUT, set VT, and restart the hold timer. Always store the data and set `first_ok`.
  - Bad word: clear `first_ok` and pulse CODE_ERR. DATA_OUT and VT are unchanged.
- Any error (width, pairing, LS bit, more than 12 bits before SYNC):
  - pulse CODE_ERR, clear `first_ok`, go to WAIT_SYNC;
  - VT is left unchanged.
- Hold timer: counts while VT=1 and restarts on each good repeated word. On reaching 1024α (two word periods), VT←0. DATA_OUT keeps its value (latch type).

## Timing
- Reset (RST=0, asynchronous): DATA_OUT=0, VT=0, CODE_ERR=0, state=WAIT_SYNC, `first_ok`=0, counters=0.
- Release is synchronous to the next INPUT_CLK rising edge.
- Input latency: 2 cycles from a DIN edge to the corresponding `din_s` edge.
- SYNC is declared on the cycle the low count reaches 64α. DATA_OUT/VT update on that clock edge and are visible in the following cycle.
- The sync low may continue indefinitely; no further SYNC is declared until a new high arrives.
- CODE_ERR is exactly one cycle wide per error event.
- Simultaneous hold-timer expiry and good word: the good word wins and VT stays 1.
- Reset mid-word: the partial word and `first_ok` are discarded, and the first word after release is never output.
- A word period at the encoder is 12×32α + 128α = 512α.

## Test plan
- ALPHA_CYCLES=4, ADDR_SET=all 01 (F); send SYNC, then word addr=FFFFFFFF data=1010, twice → CODE_ERR stays 0; after the second SYNC, DATA_OUT=4'b0101 (D0 first), VT=1.
- Single word only, then idle low → VT stays 0 and DATA_OUT stays 0.
- Two words with mismatched address pin A3=0 → CODE_ERR pulses twice; VT=0.
- Word with data 1010 then 1011 → no update; a third 1011 word → DATA_OUT=4'b1101.
- Valid pair, then DIN held low → VT falls exactly 1024α cycles after the last update; DATA_OUT is retained.
- High pulse of 20α mid-word → CODE_ERR at cycle 16α+1 of the high, FSM enters WAIT_SYNC. The next full word alone does not raise VT; RST asserted mid-word clears all outputs within the same cycle.

Source files
------------

// File: rtl/pt2272_decoder.sv
// PT2272 receive decoder: classifies PWM pulse widths on the synchronized
// input, rebuilds tri-state words and latches data after two equal words.
module pt2272_decoder #(
  parameter int ALPHA_CYCLES = 16,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 4
) (
  input  logic                   INPUT_CLK,
  input  logic                   RST,
  input  logic                   DIN,
  input  logic [2*ADDR_BITS-1:0] ADDR_SET,
  output logic [DATA_BITS-1:0]   DATA_OUT,
  output logic                   VT,
  output logic                   CODE_ERR
);

  localparam int NB = ADDR_BITS + DATA_BITS;
  localparam int CW = $clog2(64*ALPHA_CYCLES + 1);
  localparam int HW = $clog2(1024*ALPHA_CYCLES);
  localparam int BW = $clog2(NB + 1);

  localparam logic [CW-1:0] C_SMIN = CW'(2*ALPHA_CYCLES);
  localparam logic [CW-1:0] C_LMIN = CW'(8*ALPHA_CYCLES);
  localparam logic [CW-1:0] C_LMAX = CW'(16*ALPHA_CYCLES);
  localparam logic [CW-1:0] C_HERR = CW'(16*ALPHA_CYCLES + 1);
  localparam logic [CW-1:0] C_SYNC = CW'(64*ALPHA_CYCLES);
  localparam logic [HW-1:0] C_HOLD = HW'(1024*ALPHA_CYCLES - 1);
  localparam logic [BW-1:0] C_NB   = BW'(NB);

  typedef enum logic [1:0] {
    WAIT_SYNC, MEAS_HIGH, MEAS_LOW, EVAL
  } state_t;

  state_t              r_state;
  state_t              w_nstate;
  logic                r_sync1;
  logic                r_din_s;
  logic [CW-1:0]       r_wcnt;
  logic                r_hi_s;
  logic                r_hi_l;
  logic [BW-1:0]       r_bcnt;
  logic                r_half;
  logic                r_sym0;
  logic [2*NB-1:0]     r_word;
  logic                r_first_ok;
  logic [DATA_BITS-1:0] r_store;
  logic [DATA_BITS-1:0] r_data;
  logic                r_vt;
  logic [HW-1:0]       r_hold;

  logic                w_edge;
  logic                w_short;
  logic                w_long;
  logic                w_sync;
  logic                w_sym_s;
  logic                w_sym_l;
  logic                w_err;
  logic                w_start;
  logic                w_sym_first;
  logic                w_bit_done;
  logic                w_eval;
  logic                w_addr_ok;
  logic                w_data_ok;
  logic                w_good;
  logic [DATA_BITS-1:0] w_new;

  // w_edge flags the last cycle of the current din_s level
  assign w_edge  = r_sync1 ^ r_din_s;
  assign w_short = (r_wcnt >= C_SMIN) && (r_wcnt < C_LMIN);
  assign w_long  = (r_wcnt >= C_LMIN) && (r_wcnt <= C_LMAX);
  assign w_sync  = ~r_din_s & r_hi_s & (r_wcnt == C_SYNC);
  assign w_sym_s = r_hi_s & w_long;
  assign w_sym_l = r_hi_l & w_short;

  always_comb begin
    w_addr_ok = 1'b1;
    w_data_ok = 1'b1;
    w_new     = '0;
    for (int i = 0; i < ADDR_BITS; i++) begin
      if (r_word[2*i +: 2] != ADDR_SET[2*i +: 2]) w_addr_ok = 1'b0;
    end
    for (int j = 0; j < DATA_BITS; j++) begin
      w_new[j] = r_word[2*(ADDR_BITS+j)];
      if (r_word[2*(ADDR_BITS+j)+1] != r_word[2*(ADDR_BITS+j)])
        w_data_ok = 1'b0;
    end
  end

  assign w_good = (r_bcnt == C_NB) & ~r_half & w_addr_ok & w_data_ok;

  always_comb begin
    w_nstate    = r_state;
    w_err       = 1'b0;
    w_start     = 1'b0;
    w_sym_first = 1'b0;
    w_bit_done  = 1'b0;
    w_eval      = 1'b0;
    unique case (r_state)
      WAIT_SYNC: begin
        if (w_sync) begin
          w_nstate = MEAS_HIGH;
          w_start  = 1'b1;
        end
      end
      MEAS_HIGH: begin
        if (r_din_s) begin
          if (w_edge) begin
            if (w_short | w_long) w_nstate = MEAS_LOW;
            else                  w_err    = 1'b1;
          end else if (r_wcnt == C_HERR) begin
            w_err = 1'b1;
          end
        end
      end
      MEAS_LOW: begin
        if (w_sync) begin
          w_eval   = 1'b1;
          w_nstate = EVAL;
        end else if (!r_din_s) begin
          if (w_edge) begin
            if (w_sym_s | w_sym_l) begin
              w_nstate = MEAS_HIGH;
              if (!r_half)               w_sym_first = 1'b1;
              else if (r_sym0 & w_sym_s) w_err       = 1'b1;
              else if (r_bcnt == C_NB)   w_err       = 1'b1;
              else                       w_bit_done  = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end else if (!r_hi_s && r_wcnt == C_HERR) begin
            w_err = 1'b1;
          end
        end
      end
      EVAL: begin
        w_nstate = MEAS_HIGH;
        w_start  = 1'b1;
      end
    endcase
    if (w_err) w_nstate = WAIT_SYNC;
  end

  always_ff @(posedge INPUT_CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b0;
      r_din_s <= 1'b0;
      r_wcnt  <= '0;
      r_hi_s  <= 1'b0;
      r_hi_l  <= 1'b0;
      r_state <= WAIT_SYNC;
      r_bcnt  <= '0;
      r_half  <= 1'b0;
      r_sym0  <= 1'b0;
      r_word  <= '0;
    end else begin
      r_sync1 <= DIN;
      r_din_s <= r_sync1;
      if (w_edge)                r_wcnt <= CW'(1);
      else if (r_wcnt != C_SYNC) r_wcnt <= r_wcnt + 1'b1;
      // a consumed sync clears the short-high mark so a long idle low
      // cannot declare a second sync
      if (r_din_s & w_edge) begin
        r_hi_s <= w_short;
        r_hi_l <= w_long;
      end else if (w_sync) begin
        r_hi_s <= 1'b0;
      end
      r_state <= w_nstate;
      if (w_start) begin
        r_bcnt <= '0;
        r_half <= 1'b0;
      end
      if (w_sym_first) begin
        r_half <= 1'b1;
        r_sym0 <= w_sym_l;
      end
      if (w_bit_done) begin
        r_half <= 1'b0;
        r_bcnt <= r_bcnt + 1'b1;
        r_word <= {r_sym0, w_sym_l, r_word[2*NB-1:2]};
      end
    end
  end

  always_ff @(posedge INPUT_CLK or negedge RST) begin
    if (!RST) begin
      r_first_ok <= 1'b0;
      r_store    <= '0;
      r_data     <= '0;
      r_vt       <= 1'b0;
      r_hold     <= '0;
    end else begin
      if (r_vt) begin
        if (r_hold == C_HOLD) begin
          r_vt   <= 1'b0;
          r_hold <= '0;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end
      if (w_err) r_first_ok <= 1'b0;
      if (w_eval) begin
        if (w_good) begin
          r_store    <= w_new;
          r_first_ok <= 1'b1;
          if (r_first_ok && r_store == w_new) begin
            r_data <= w_new;
            r_vt   <= 1'b1;
            r_hold <= '0;
          end
        end else begin
          r_first_ok <= 1'b0;
        end
      end
    end
  end

  assign DATA_OUT = r_data;
  assign VT       = r_vt;
  assign CODE_ERR = w_err | (w_eval & ~w_good);

endmodule

// File: tb/tb_pt2272_decoder.sv
// Directed bench for pt2272_decoder: encoder-style word stream, table of
// words with expected outputs, plus hand-written timing/reset sequences.
`timescale 1ns/1ps
module tb_pt2272_decoder;

  localparam int A = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [15:0] aset = 16'h5555;
  logic [3:0]  dout;
  logic        vt;
  logic        cerr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    logic [15:0] aset;
    logic [23:0] word;
    int          err;
    logic        vt;
    logic [3:0]  dout;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  pt2272_decoder #(
    .ALPHA_CYCLES(A),
    .ADDR_BITS(8),
    .DATA_BITS(4)
  ) dut (
    .INPUT_CLK(clk),
    .RST(rst_n),
    .DIN(din),
    .ADDR_SET(aset),
    .DATA_OUT(dout),
    .VT(vt),
    .CODE_ERR(cerr)
  );

  always @(negedge clk) if (cerr) n_err++;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic hold_din(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sym(input logic l);
    hold_din(1'b1, (l ? 12 : 4) * A);
    hold_din(1'b0, (l ? 4 : 12) * A);
  endtask

  task automatic send_sync();
    hold_din(1'b1, 4 * A);
    hold_din(1'b0, 124 * A);
  endtask

  function automatic logic [23:0] mk(input logic [15:0] a,
                                     input logic [3:0] d);
    logic [23:0] w;
    w[15:0] = a;
    for (int j = 0; j < 4; j++) w[16+2*j +: 2] = {d[j], d[j]};
    return w;
  endfunction

  task automatic send_bits(input logic [23:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      send_sym(w[2*i+1]);
      send_sym(w[2*i]);
    end
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 12);
    send_sync();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [23:0] wf;
    logic [23:0] w;
    int e0;
    int t;
    int n;
    int first;
    int pulses;

    wf = mk(16'h71CC, 4'b0111);
    wf[23:22] = 2'b01;
    tbl[0]  = '{1'b1, 16'h5555, mk(16'h5555, 4'b0101), 0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 16'h5555, mk(16'h5555, 4'b0101), 0, 1'b1, 4'h5};
    tbl[2]  = '{1'b1, 16'h5555, mk(16'h5515, 4'b0101), 1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 16'h5555, mk(16'h5515, 4'b0101), 1, 1'b0, 4'h0};
    tbl[4]  = '{1'b1, 16'h5555, mk(16'h5555, 4'b0101), 0, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 16'h5555, mk(16'h5555, 4'b1101), 0, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 16'h5555, mk(16'h5555, 4'b1101), 0, 1'b1, 4'hD};
    tbl[7]  = '{1'b1, 16'h71CC, mk(16'h71CC, 4'b1111), 0, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 16'h71CC, mk(16'h71CC, 4'b1111), 0, 1'b1, 4'hF};
    tbl[9]  = '{1'b0, 16'h71CC, mk(16'h71CC, 4'b0110), 0, 1'b1, 4'hF};
    tbl[10] = '{1'b0, 16'h71CC, mk(16'h71CC, 4'b0110), 0, 1'b1, 4'h6};
    tbl[11] = '{1'b0, 16'h71CC, wf,                    1, 1'b1, 4'h6};
    tbl[12] = '{1'b0, 16'h71CC, mk(16'h71CC, 4'b0110), 0, 1'b0, 4'h6};
    tbl[13] = '{1'b0, 16'h71CC, mk(16'h71CC, 4'b0110), 0, 1'b1, 4'h6};
    tbl[14] = '{1'b1, 16'h71CE, mk(16'h71CC, 4'b0110), 1, 1'b0, 4'h0};
    tbl[15] = '{1'b0, 16'h71CE, mk(16'h71CC, 4'b0110), 1, 1'b0, 4'h0};

    repeat (3) @(negedge clk);
    check("reset dout", dout, 0);
    check("reset vt", vt, 0);
    check("reset code_err", cerr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      aset = tbl[i].aset;
      if (tbl[i].rst) begin
        do_reset();
        send_sync();
      end
      e0 = n_err;
      send_word(tbl[i].word);
      check($sformatf("row%0d code_err pulses", i), n_err - e0, tbl[i].err);
      check($sformatf("row%0d vt", i), vt, tbl[i].vt);
      check($sformatf("row%0d dout", i), dout, tbl[i].dout);
    end

    // single word then long idle low: no output, no repeated sync
    aset = 16'h5555;
    w = mk(16'h5555, 4'b0101);
    do_reset();
    send_sync();
    e0 = n_err;
    send_word(w);
    hold_din(1'b0, 2000);
    check("idle code_err", n_err - e0, 0);
    check("idle vt", vt, 0);
    check("idle dout", dout, 0);

    // hold timer: VT drops exactly 1024 alpha after the update
    do_reset();
    send_sync();
    send_word(w);
    send_bits(w, 12);
    hold_din(1'b1, 4 * A);
    din = 1'b0;
    t = 0;
    while (!vt && t < 200 * A) begin
      @(negedge clk);
      t++;
    end
    check("hold vt rise", vt, 1);
    n = 0;
    while (vt && n < 2000 * A) begin
      @(negedge clk);
      n++;
    end
    check("hold vt duration", n, 1024 * A);
    check("hold dout kept", dout, 5);

    // 20 alpha high mid-word; DIN sync adds 2 cycles to the 16a+1 count
    do_reset();
    send_sync();
    send_word(w);
    send_bits(w, 3);
    din = 1'b1;
    first = 0;
    pulses = 0;
    for (int i = 1; i <= 20 * A; i++) begin
      @(negedge clk);
      if (cerr) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("long high err cycle", first, 16 * A + 2);
    check("long high err width", pulses, 1);
    hold_din(1'b0, 12 * A);
    e0 = n_err;
    send_sync();
    send_word(w);
    check("after err code_err", n_err - e0, 0);
    check("after err vt", vt, 0);

    // asynchronous reset mid-word
    w = mk(16'h5555, 4'b1001);
    do_reset();
    send_sync();
    send_word(w);
    send_word(w);
    check("pre-rst vt", vt, 1);
    check("pre-rst dout", dout, 9);
    send_bits(w, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    check("async rst vt", vt, 0);
    check("async rst dout", dout, 0);
    check("async rst code_err", cerr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_sync();
    send_word(w);
    check("post-rst first vt", vt, 0);
    check("post-rst first dout", dout, 0);
    send_word(w);
    check("post-rst pair vt", vt, 1);
    check("post-rst pair dout", dout, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
